// File: rtl/usr_pkg.sv
// Shared definitions for the universal sequential shifter.
// Contents: op-code localparams, FSM state encoding and a helper that
// classifies an op as a one-position shift/rotate step.
package usr_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd2;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd3;
  localparam logic [OP_W-1:0] OP_ASR  = 3'd4;
  localparam logic [OP_W-1:0] OP_ROL  = 3'd5;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True for ops that move bits one position per RUN edge.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// One-position shift/rotate step (combinational).
// Ports:
//   q      in  N  current register contents
//   op     in  3  operation code
//   si     in  1  serial input for SHL/SHR
//   q_nxt  out N  contents after one step (q for non-shift ops)
//   so_nxt out 1  bit leaving the register (0 for non-shift ops)
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    q,
  input  logic [OP_W-1:0] op,
  input  logic            si,
  output logic [N-1:0]    q_nxt,
  output logic            so_nxt
);

  always_comb begin
    q_nxt  = q;
    so_nxt = 1'b0;
    case (op)
      OP_SHL: begin q_nxt = {q[N-2:0], si};       so_nxt = q[N-1]; end
      OP_SHR: begin q_nxt = {si, q[N-1:1]};       so_nxt = q[0];   end
      OP_ASR: begin q_nxt = {q[N-1], q[N-1:1]};   so_nxt = q[0];   end
      OP_ROL: begin q_nxt = {q[N-2:0], q[N-1]};   so_nxt = q[N-1]; end
      OP_ROR: begin q_nxt = {q[0], q[N-1:1]};     so_nxt = q[0];   end
      default: begin q_nxt = q;                   so_nxt = 1'b0;   end
    endcase
  end

endmodule

// File: rtl/usr_seq_shifter.sv
// Command-driven universal shift register: multi-position shifts/rotates
// executed one position per clock behind a valid/ready handshake.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cmd_valid/ready  command handshake (ready only in IDLE)
//   cmd_op, cmd_amt  operation and position count, captured on accept
//   d                parallel load data, captured on accept
//   si               serial input, sampled on every shift edge
//   q, so            register contents, last bit shifted out
//   busy, done       command executing, one-cycle completion pulse
module usr_seq_shifter
  import usr_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [AW-1:0]   cmd_amt,
  input  logic [N-1:0]    d,
  input  logic            si,
  output logic [N-1:0]    q,
  output logic            so,
  output logic            busy,
  output logic            done
);

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [OP_W-1:0] op_r, op_nxt;
  logic [N-1:0]    d_r, d_nxt;
  logic [N-1:0]    q_nxt;
  logic            so_nxt;
  logic            done_nxt;
  logic [N-1:0]    step_q;
  logic            step_so;

  usr_step #(.N(N)) u_step (
    .q      (q),
    .op     (op_r),
    .si     (si),
    .q_nxt  (step_q),
    .so_nxt (step_so)
  );

  // State, command capture and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_r      <= OP_HOLD;
      d_r       <= '0;
      q         <= '0;
      so        <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_r      <= op_nxt;
      d_r       <= d_nxt;
      q         <= q_nxt;
      so        <= so_nxt;
      done      <= done_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt == ST_RUN);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    d_nxt     = d_r;
    q_nxt     = q;
    so_nxt    = so;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        // The accept edge only captures the command; q is untouched.
        if (cmd_valid) begin
          state_nxt = ST_RUN;
          cnt_nxt   = cmd_amt;
          op_nxt    = cmd_op;
          if (cmd_op == OP_LOAD) d_nxt = d;
        end
      end
      ST_RUN: begin
        if (is_shift(op_r) && (cnt != '0)) begin
          q_nxt  = step_q;
          so_nxt = step_so;
        end
        if (op_r == OP_LOAD) q_nxt = d_r;
        // Non-shift ops and amt<=1 finish on their first RUN edge.
        if (is_shift(op_r) && (cnt > AW'(1))) begin
          cnt_nxt = cnt - AW'(1);
        end else begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_seq_shifter.sv
// Directed self-checking bench for usr_seq_shifter (N=8).
module tb_usr_seq_shifter;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic [N-1:0]  d;
  logic          si;
  logic [N-1:0]  q;
  logic          so;
  logic          busy;
  logic          done;

  int ncmp = 0;
  int nerr = 0;

  usr_seq_shifter #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .d         (d),
    .si        (si),
    .q         (q),
    .so        (so),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check latency, result and handshake.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] amt,
                         input logic [7:0] dv, input logic [7:0] si_vec,
                         input logic [7:0] exp_q, input logic exp_so);
    int n;
    logic [7:0] q0;
    q0 = q;
    n  = (op >= 3'd2 && op <= 3'd6 && amt != 3'd0) ? int'(amt) : 1;
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; d = dv;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd1; cmd_amt = 3'd7; d = 8'h3C;
    chk({tag, "_acc_q"}, 32'(q), 32'(q0));
    chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_run_done"}, 32'(done), 32'd0);
      si = si_vec[i];
      tick();
    end
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_so"}, 32'(so), 32'(exp_so));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_amt = 3'd0; d = 8'hFF; si = 1'b1;

    // Reset with a command pending: nothing is accepted.
    tick(); tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_so", 32'(so), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    chk("post_rst_q", 32'(q), 32'h00);

    // Load then shift in serial bits 1,0,1.
    run_cmd("load_a5", 3'd1, 3'd0, 8'hA5, 8'h00, 8'hA5, 1'b0);
    run_cmd("shl3",    3'd2, 3'd3, 8'h00, 8'b0000_0101, 8'h2D, 1'b1);
    run_cmd("rol4",    3'd5, 3'd4, 8'h00, 8'h00, 8'hD2, 1'b0);

    // Long rotates, arithmetic fill and serial-out of the last bit.
    run_cmd("load_81", 3'd1, 3'd5, 8'h81, 8'h00, 8'h81, 1'b0);
    run_cmd("ror7",    3'd6, 3'd7, 8'h00, 8'hFF, 8'h03, 1'b0);
    run_cmd("load_80", 3'd1, 3'd0, 8'h80, 8'h00, 8'h80, 1'b0);
    run_cmd("asr7",    3'd4, 3'd7, 8'h00, 8'h00, 8'hFF, 1'b0);
    run_cmd("load_01", 3'd1, 3'd0, 8'h01, 8'h00, 8'h01, 1'b0);
    run_cmd("shr1",    3'd3, 3'd1, 8'h00, 8'h00, 8'h00, 1'b1);

    // Zero amount, HOLD and reserved op: one RUN cycle, q and so kept.
    run_cmd("load_5a", 3'd1, 3'd0, 8'h5A, 8'h00, 8'h5A, 1'b1);
    run_cmd("shl0",    3'd2, 3'd0, 8'h00, 8'hFF, 8'h5A, 1'b1);
    run_cmd("hold3",   3'd0, 3'd3, 8'h00, 8'hFF, 8'h5A, 1'b1);
    run_cmd("rsvd2",   3'd7, 3'd2, 8'hFF, 8'hFF, 8'h5A, 1'b1);

    // Commands presented while busy are ignored; accept in the done cycle.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd2; si = 1'b0;
    tick();
    cmd_op = 3'd1; cmd_amt = 3'd0; d = 8'hFF;
    tick();
    chk("b2b_step1_q", 32'(q), 32'hB4);
    chk("b2b_step1_done", 32'(done), 32'd0);
    tick();
    chk("b2b_fin_q", 32'(q), 32'h68);
    chk("b2b_fin_so", 32'(so), 32'd1);
    chk("b2b_fin_done", 32'(done), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_acc_busy", 32'(busy), 32'd1);
    chk("b2b_acc_done", 32'(done), 32'd0);
    chk("b2b_acc_q", 32'(q), 32'h68);
    tick();
    chk("b2b_load_q", 32'(q), 32'hFF);
    chk("b2b_load_done", 32'(done), 32'd1);

    // Reset at the second step of a five-step shift aborts it.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd5; si = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_step1_q", 32'(q), 32'hFE);
    rst = 1'b1;
    tick();
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_idle_q", 32'(q), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
